pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline-control sequencer for the 5-stage RV core. It consumes the stall and redirect requests produced by the hazard unit, the branch resolver, the multi-cycle execute unit and the data-memory port, and emits the per-stage stall/flush controls that the pipeline registers and the PC obey. It adds sequential handling that purely combinational hazard detection cannot provide:
- the 2-cycle load→branch-dependency stall;
- N-cycle holds for multi-cycle execute ops;
- whole-pipe freeze on memory wait;
- a stall-cycle performance counter.

## Interface
Parameters:
- LAT_W, 4, width of multi-cycle latency field
- CNT_W, 32, width of stall performance counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- hazard_stall  in  1  load-use / M-stage branch stall request from hazard unit
- lb_dep  in  1  load in E whose rd is a source of the branch in D
- redirect_D  in  1  branch/jump resolved taken in D
- ex_mc_start  in  1  multi-cycle op (mul/div) present in E, first cycle
- ex_mc_lat  in  LAT_W  total stall cycles required by that op
- dmem_wait  in  1  data memory not ready; freeze entire pipe
- stall_PC  out  1  hold PC
- stall_F_to_D  out  1  hold F/D register
- stall_D_to_E  out  1  hold D/E register
- stall_E_to_M  out  1  hold E/M register
- stall_M_to_W  out  1  hold M/W register
- flush_F_to_D  out  1  load bubble into F/D
- flush_D_to_E  out  1  load bubble into D/E
- flush_E_to_M  out  1  load bubble into E/M
- mc_last  out  1  final stall cycle of a multi-cycle op; execute unit result valid
- stall_count  out  CNT_W  cycles with stall_PC=1 since reset

## Operation
- FSM states: RUN, LB_STALL, MC_WAIT. Internal down-counter mc_cnt (LAT_W bits).
- Priority, highest first: dmem_wait, MC_WAIT, LB_STALL, RUN requests.
- dmem_wait=1 (any state): all five stall outputs = 1, all flushes = 0, mc_last = 0; FSM state and mc_cnt held.
- RUN, ex_mc_start=1, ex_mc_lat≥1:
  - outputs: stall_PC, stall_F_to_D, stall_D_to_E = 1; flush_E_to_M = 1; flush_D_to_E forced 0, even if hazard_stall.
  - If lat=1: mc_last=1 and stay RUN.
  - Otherwise: mc_cnt←lat−1 and go to MC_WAIT.
- RUN, ex_mc_start=1, ex_mc_lat=0: ignored, no stall.
- MC_WAIT:
  - outputs same as the RUN multi-cycle case.
  - Each cycle mc_cnt−1.
  - When mc_cnt=1: mc_last=1 and go to RUN next edge.
  - ex_mc_start, lb_dep, hazard_stall ignored.
- RUN, lb_dep=1 (no ex_mc_start): stall_PC, stall_F_to_D = 1, flush_D_to_E = 1; go to LB_STALL.
- LB_STALL: same outputs for exactly one cycle, then RUN. lb_dep is ignored in this state. Total stall = 2 cycles.
- RUN, hazard_stall=1: stall_PC, stall_F_to_D, flush_D_to_E = 1 (combinational, no state change).
- redirect_D=1 with no stall active: flush_F_to_D = 1, PC not stalled.
  - If any stall is active the same cycle, redirect is suppressed (flush_F_to_D=0). The branch remains in D and re-resolves.
- ex_mc_start and lb_dep simultaneously is illegal (E holds one instruction); ex_mc_start wins.
- stall_count increments by 1 each cycle stall_PC=1 and wraps modulo 2^CNT_W.

## Timing
- All stall/flush outputs and mc_last are combinational from state, mc_cnt and inputs. They are valid in the same cycle as the request; no added latency.
- State, mc_cnt and stall_count update on the rising clk edge.
- Reset (async, any state including mid-MC_WAIT/LB_STALL):
  - state=RUN, mc_cnt=0, stall_count=0;
  - with inputs low, all stall/flush outputs and mc_last = 0.
- Multi-cycle op of latency L: exactly L consecutive stall cycles, excluding dmem_wait cycles, which extend the sequence. mc_last is high in the L-th.
- Load→branch: exactly 2 consecutive stall cycles, extended by any dmem_wait cycles.
- stall_count reflects a stall cycle one edge after that cycle.

## Test plan
- Reset then idle: rst pulse mid-MC_WAIT (mc_cnt=3) → all outputs 0, state RUN, stall_count=0 immediately (async).
- ex_mc_start, lat=4 → stall_PC/F_to_D/D_to_E=1, flush_E_to_M=1 for 4 cycles, flush_D_to_E=0 throughout, mc_last only in cycle 4, stall_count=4 afterwards.
- lat=4 with dmem_wait high in cycle 2 for 3 cycles → all stalls high, no flushes during wait, 7 total stall cycles, mc_last in cycle 7.
- lb_dep one cycle → stall_PC=1, flush_D_to_E=1 for exactly 2 cycles, then RUN. lb_dep held high in LB_STALL → still exactly 2.
- redirect_D alone → flush_F_to_D=1, stall_PC=0. redirect_D + hazard_stall same cycle → flush_F_to_D=0, stall_PC=1, flush_D_to_E=1.
- ex_mc_start lat=1 with hazard_stall → single stall cycle, mc_last=1, flush_D_to_E=0, flush_E_to_M=1. lat=0 → no outputs asserted.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline-control sequencer: turns hazard, load->branch, multi-cycle execute and
// memory-wait requests into per-stage stall/flush controls plus a stall counter.
module pipe_ctrl #(
    parameter int LAT_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             lb_dep,
    input  logic             redirect_D,
    input  logic             ex_mc_start,
    input  logic [LAT_W-1:0] ex_mc_lat,
    input  logic             dmem_wait,
    output logic             stall_PC,
    output logic             stall_F_to_D,
    output logic             stall_D_to_E,
    output logic             stall_E_to_M,
    output logic             stall_M_to_W,
    output logic             flush_F_to_D,
    output logic             flush_D_to_E,
    output logic             flush_E_to_M,
    output logic             mc_last,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LB_STALL = 2'd1,
        MC_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [LAT_W-1:0] r_mc_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_mc_go;

    // A zero-latency multi-cycle request is treated as if no request were present.
    assign w_mc_go     = (r_state == RUN) && ex_mc_start && (ex_mc_lat != '0);
    assign stall_count = r_stall_count;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall_PC     = 1'b0;
        stall_F_to_D = 1'b0;
        stall_D_to_E = 1'b0;
        stall_E_to_M = 1'b0;
        stall_M_to_W = 1'b0;
        flush_F_to_D = 1'b0;
        flush_D_to_E = 1'b0;
        flush_E_to_M = 1'b0;
        mc_last      = 1'b0;

        if (dmem_wait) begin
            stall_PC     = 1'b1;
            stall_F_to_D = 1'b1;
            stall_D_to_E = 1'b1;
            stall_E_to_M = 1'b1;
            stall_M_to_W = 1'b1;
        end else if (r_state == MC_WAIT || w_mc_go) begin
            stall_PC     = 1'b1;
            stall_F_to_D = 1'b1;
            stall_D_to_E = 1'b1;
            flush_E_to_M = 1'b1;
            mc_last      = (r_state == MC_WAIT) ? (r_mc_cnt == LAT_W'(1))
                                                : (ex_mc_lat == LAT_W'(1));
        end else if (r_state == LB_STALL || lb_dep || hazard_stall) begin
            stall_PC     = 1'b1;
            stall_F_to_D = 1'b1;
            flush_D_to_E = 1'b1;
        end else if (redirect_D) begin
            flush_F_to_D = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_mc_cnt      <= '0;
            r_stall_count <= '0;
        end else begin
            if (stall_PC) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (!dmem_wait) begin
                case (r_state)
                    RUN: begin
                        if (w_mc_go) begin
                            if (ex_mc_lat != LAT_W'(1)) begin
                                r_mc_cnt <= ex_mc_lat - LAT_W'(1);
                                r_state  <= MC_WAIT;
                            end
                        end else if (lb_dep && !ex_mc_start) begin
                            r_state <= LB_STALL;
                        end
                    end
                    LB_STALL: r_state <= RUN;
                    MC_WAIT: begin
                        r_mc_cnt <= r_mc_cnt - LAT_W'(1);
                        if (r_mc_cnt == LAT_W'(1)) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed cycles with hand-computed output vectors, plus a
// cycles-remaining model compared against the DUT on every falling edge.
module tb_pipe_ctrl;

    localparam int LAT_W = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             hazard_stall, lb_dep, redirect_D, ex_mc_start, dmem_wait;
    logic [LAT_W-1:0] ex_mc_lat;
    logic             stall_PC, stall_F_to_D, stall_D_to_E, stall_E_to_M, stall_M_to_W;
    logic             flush_F_to_D, flush_D_to_E, flush_E_to_M, mc_last;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Output vector: {sPC,sFD,sDE,sEM,sMW,fFD,fDE,fEM,mc_last}
    logic [8:0] w_vec;
    assign w_vec = {stall_PC, stall_F_to_D, stall_D_to_E, stall_E_to_M, stall_M_to_W,
                    flush_F_to_D, flush_D_to_E, flush_E_to_M, mc_last};

    pipe_ctrl #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .hazard_stall(hazard_stall), .lb_dep(lb_dep), .redirect_D(redirect_D),
        .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat), .dmem_wait(dmem_wait),
        .stall_PC(stall_PC), .stall_F_to_D(stall_F_to_D), .stall_D_to_E(stall_D_to_E),
        .stall_E_to_M(stall_E_to_M), .stall_M_to_W(stall_M_to_W),
        .flush_F_to_D(flush_F_to_D), .flush_D_to_E(flush_D_to_E),
        .flush_E_to_M(flush_E_to_M), .mc_last(mc_last), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: how many stall cycles of the current multi-cycle op / load-branch
    // stall are still owed, counting the present cycle; memory-wait cycles do not pay them down.
    int         m_mc_left = 0;
    int         m_lb_left = 0;
    logic [31:0] m_cnt    = '0;

    function automatic logic [8:0] model_vec();
        logic [8:0] v;
        v = '0;
        if (dmem_wait)                          v = 9'b1_1111_0000;
        else if (m_mc_left > 0)                 v = {7'b1_1100_00, 1'b1, m_mc_left == 1};
        else if (m_lb_left > 0)                 v = 9'b1_1000_0100;
        else if (ex_mc_start && ex_mc_lat != 0) v = {7'b1_1100_00, 1'b1, ex_mc_lat == 1};
        else if (lb_dep || hazard_stall)        v = 9'b1_1000_0100;
        else if (redirect_D)                    v = 9'b0_0000_1000;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_mc_left = 0;
            m_lb_left = 0;
            m_cnt     = '0;
        end else if (chk_en) begin
            logic [8:0] exp_v;
            exp_v = model_vec();
            check("model_outputs", 64'(w_vec), 64'(exp_v));
            check("model_stall_count", 64'(stall_count), 64'(m_cnt));
            if (exp_v[8]) m_cnt = m_cnt + 1;
            if (!dmem_wait) begin
                if (m_mc_left > 0)                      m_mc_left--;
                else if (m_lb_left > 0)                 m_lb_left--;
                else if (ex_mc_start && ex_mc_lat != 0) m_mc_left = int'(ex_mc_lat) - 1;
                else if (lb_dep)                        m_lb_left = 1;
            end
        end
    end

    task automatic set_in(input logic hz, input logic lb, input logic rd, input logic mcs,
                          input logic [LAT_W-1:0] lat, input logic dw);
        hazard_stall = hz; lb_dep = lb; redirect_D = rd;
        ex_mc_start = mcs; ex_mc_lat = lat; dmem_wait = dw;
    endtask

    // One directed cycle: starts just after a rising edge, checks the literal vector, ends just after the next.
    task automatic cyc(input string nm, input logic hz, input logic lb, input logic rd,
                       input logic mcs, input logic [LAT_W-1:0] lat, input logic dw,
                       input logic [8:0] exp_v);
        set_in(hz, lb, rd, mcs, lat, dw);
        #1;
        check(nm, 64'(w_vec), 64'(exp_v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_outputs", 64'(w_vec), 64'(0));
        check("reset_count", 64'(stall_count), 64'(0));
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Async reset in the middle of MC_WAIT (mc_cnt=3)
        cyc("rst_mc_start", 0, 0, 0, 1, 4, 0, 9'h1C2);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_mc_wait", 64'(w_vec), 64'h1C2);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 64'(w_vec), 64'(0));
        check("async_rst_count", 64'(stall_count), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("after_rst_idle", 64'(w_vec), 64'(0));
        @(posedge clk);
        #1;

        // Multi-cycle op, latency 4
        cyc("mc4_c1", 0, 0, 0, 1, 4, 0, 9'h1C2);
        cyc("mc4_c2", 0, 0, 0, 0, 0, 0, 9'h1C2);
        cyc("mc4_c3", 0, 0, 0, 0, 0, 0, 9'h1C2);
        cyc("mc4_c4", 0, 0, 0, 0, 0, 0, 9'h1C3);
        check("mc4_count", 64'(stall_count), 64'(4));
        cyc("mc4_done", 0, 0, 0, 0, 0, 0, 9'h000);

        // Latency 4 with a 3-cycle memory wait from cycle 2
        cyc("mcdw_c1", 0, 0, 0, 1, 4, 0, 9'h1C2);
        cyc("mcdw_c2", 0, 0, 0, 0, 0, 1, 9'h1F0);
        cyc("mcdw_c3", 0, 0, 0, 0, 0, 1, 9'h1F0);
        cyc("mcdw_c4", 0, 0, 0, 0, 0, 1, 9'h1F0);
        cyc("mcdw_c5", 0, 0, 0, 0, 0, 0, 9'h1C2);
        cyc("mcdw_c6", 0, 0, 0, 0, 0, 0, 9'h1C2);
        cyc("mcdw_c7", 0, 0, 0, 0, 0, 0, 9'h1C3);
        check("mcdw_count", 64'(stall_count), 64'(11));

        // Load->branch: single-cycle lb_dep, then lb_dep held into LB_STALL
        cyc("lb1_c1", 0, 1, 0, 0, 0, 0, 9'h184);
        cyc("lb1_c2", 0, 0, 0, 0, 0, 0, 9'h184);
        cyc("lb1_c3", 0, 0, 0, 0, 0, 0, 9'h000);
        cyc("lbh_c1", 0, 1, 0, 0, 0, 0, 9'h184);
        cyc("lbh_c2", 0, 1, 0, 0, 0, 0, 9'h184);
        cyc("lbh_c3", 0, 0, 0, 0, 0, 0, 9'h000);
        check("lb_count", 64'(stall_count), 64'(15));

        // Redirect alone, then redirect suppressed by a hazard stall
        cyc("redir_alone", 0, 0, 1, 0, 0, 0, 9'h008);
        cyc("redir_hazard", 1, 0, 1, 0, 0, 0, 9'h184);

        // Latency 1 with hazard_stall, then latency 0
        cyc("mc1_hazard", 1, 0, 0, 1, 1, 0, 9'h1C3);
        cyc("mc1_after", 0, 0, 0, 0, 0, 0, 9'h000);
        cyc("mc0_ignored", 0, 0, 0, 1, 0, 0, 9'h000);
        check("mc1_count", 64'(stall_count), 64'(17));

        // Load->branch stall extended by a memory wait
        cyc("lbdw_c1", 0, 1, 0, 0, 0, 0, 9'h184);
        cyc("lbdw_c2", 0, 0, 0, 0, 0, 1, 9'h1F0);
        cyc("lbdw_c3", 0, 0, 0, 0, 0, 0, 9'h184);
        cyc("lbdw_c4", 0, 0, 0, 0, 0, 0, 9'h000);
        check("final_count", 64'(stall_count), 64'(20));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
